regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//   Parametrised 2-read/1-write register file with write-through bypass and an optional
//   hard-wired zero register. Adds a per-register busy scoreboard that tracks writes
//   issued but not yet written back, so decode can detect RAW hazards and stall.
//   Sits between decode (read, issue) and writeback (write) in the 16-bit datapath.
// PARAMETERS
//   DATA_W    16  register width in bits
//   ADDR_W    4   address width; DEPTH = 2**ADDR_W registers
//   ZERO_REG  1   1: reg 0 always reads 0, ignores writes, never busy
//   BYPASS    1   1: a same-cycle write is forwarded to matching read ports
// PORTS
//   clk          in   1        rising-edge clock
//   rst          in   1        asynchronous reset, active-high
//   wr_en        in   1        writeback strobe
//   wr_addr      in   ADDR_W   writeback register
//   wr_data      in   DATA_W   writeback data
//   rd_addr_a    in   ADDR_W   read port A address
//   rd_data_a    out  DATA_W   read port A data (combinational)
//   busy_a       out  1        port A register has a pending write
//   rd_addr_b    in   ADDR_W   read port B address
//   rd_data_b    out  DATA_W   read port B data (combinational)
//   busy_b       out  1        port B register has a pending write
//   issue_en     in   1        decode issued an instruction that will write issue_addr
//   issue_addr   in   ADDR_W   destination of the issued instruction
//   flush        in   1        synchronous clear of all busy bits (pipeline flush)
//   pending_cnt  out  ADDR_W+1 number of registers currently busy
//   sb_full      out  1        pending_cnt == DEPTH (DEPTH-1 when ZERO_REG)
// BEHAVIOUR
//   - Reset: all registers 0; all busy bits 0; pending_cnt 0; sb_full 0. Read outputs
//     then reflect the cleared array. Reset mid-operation discards pending state.
//   - Write: on posedge clk, if wr_en, regs[wr_addr] <= wr_data. Skipped for addr 0 when ZERO_REG.
//   - Read: async. rd_data_x = regs[rd_addr_x]. If BYPASS and wr_en and wr_addr==rd_addr_x
//     (and not reg 0 under ZERO_REG), rd_data_x = wr_data in the same cycle.
//     Otherwise the new value is visible the cycle after the write.
//   - Reg 0 under ZERO_REG: rd_data 0, busy 0 regardless of writes or issues.
//   - Busy bits, next-state per register r, in priority order:
//       flush                       -> 0  (flush overrides issue and wr_en)
//       issue_en && issue_addr==r   -> 1  (set wins over same-cycle clear)
//       wr_en && wr_addr==r         -> 0
//       else                        -> hold
//     issue_en to reg 0 under ZERO_REG is ignored.
//   - busy_x = busy[rd_addr_x], except 0 when BYPASS and a same-cycle wr_en to that address
//     clears it. An issue_en in the same cycle does not raise busy_x until the next cycle.
//   - Writes to non-busy registers are legal (they update data) and do not change busy.
//   - pending_cnt is registered and equals popcount(busy) at all times. Maintain it
//     incrementally: +1 when a clear bit is set, -1 when a set bit is cleared, net 0 when
//     a set and a clear hit different registers, 0 on flush.
//   - Re-issue to an already-busy register leaves the count unchanged.
//   - sb_full is combinational from pending_cnt. Issue while full is still accepted;
//     the count cannot exceed the maximum.
// STRUCTURE
//   - Shared package (cpu_pkg): DATA_W / ADDR_W defaults and the reg_addr_t / word_t
//     typedefs used by decode and writeback.
//   - One sub-module, regfile_sb_bits: the busy vector, pending_cnt and sb_full.
//   - The top holds the storage array, write decode and the two bypass read muxes.
// TESTING
//   1 Reset: write 0xBEEF to r5, assert rst -> rd r5 = 0x0000, pending_cnt 0, busy 0.
//   2 Write/read: wr r3 = 0x1234 -> next cycle rd_data_a(r3) = 0x1234. With a same-cycle
//     read of r3, BYPASS=1 gives 0x1234; BYPASS=0 gives the old value 0x0000.
//   3 Zero reg: wr r0 = 0xFFFF and issue r0 -> rd r0 = 0x0000, busy 0, pending_cnt 0.
//   4 Scoreboard:
//     - issue r7 -> next cycle busy_a(r7) = 1, pending_cnt 1.
//     - wr r7 = 0x00AA -> same cycle busy_a = 0 and rd = 0x00AA; next cycle pending_cnt 0.
//   5 Simultaneous:
//     - issue r2 and wr r2 in one cycle -> busy r2 = 1, cnt unchanged + 1.
//     - issue r4 and wr r9 (r9 busy) in one cycle -> cnt net unchanged.
//   6 Full/flush: issue r1..r15 -> pending_cnt 15, sb_full 1. Then flush together with
//     issue r6 -> all busy 0, pending_cnt 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Purpose: shared datapath widths and register-file types used by decode and writeback.
`timescale 1ns/1ps
package cpu_pkg;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_sb_bits.sv
// Purpose: per-register busy scoreboard with an incrementally maintained pending count.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_wr_en, i_wr_addr  writeback (clears the busy bit of the written register)
//   i_issue_en/_addr    decode issue (sets the busy bit of the destination)
//   i_flush             clears every busy bit
//   o_busy              registered busy vector, one bit per register
//   o_pending_cnt       registered popcount of o_busy
//   o_sb_full_c         combinational: every trackable register is busy
`timescale 1ns/1ps
module regfile_sb_bits
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = cpu_pkg::ADDR_W,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_W-1:0]     i_wr_addr,
  input  logic                  i_issue_en,
  input  logic [ADDR_W-1:0]     i_issue_addr,
  input  logic                  i_flush,
  output logic [(1<<ADDR_W)-1:0] o_busy,
  output logic [ADDR_W:0]       o_pending_cnt,
  output logic                  o_sb_full_c
);
  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned CW      = ADDR_W + 1;
  localparam int unsigned MAX_CNT = ZERO_REG ? DEPTH - 1 : DEPTH;

  logic [DEPTH-1:0] r_busy, w_busy_nxt, w_set, w_clr;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             w_issue_ok, w_inc, w_dec;

  // Next busy vector and count; set beats a same-register clear, flush beats both.
  always_comb begin
    w_issue_ok = i_issue_en && !(ZERO_REG && (i_issue_addr == '0));
    w_set      = '0;
    w_clr      = '0;
    if (w_issue_ok) w_set[i_issue_addr] = 1'b1;
    if (i_wr_en)    w_clr[i_wr_addr]    = 1'b1;
    // Count moves only on real 0->1 / 1->0 transitions of a bit.
    w_inc      = w_issue_ok && !r_busy[i_issue_addr];
    w_dec      = i_wr_en && r_busy[i_wr_addr] &&
                 !(w_issue_ok && (i_issue_addr == i_wr_addr));
    w_busy_nxt = (r_busy & ~w_clr) | w_set;
    w_cnt_nxt  = r_cnt + CW'(w_inc) - CW'(w_dec);
    if (i_flush) begin
      w_busy_nxt = '0;
      w_cnt_nxt  = '0;
    end
  end

  // Scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign o_busy        = r_busy;
  assign o_pending_cnt = r_cnt;
  assign o_sb_full_c   = (r_cnt == CW'(MAX_CNT));
endmodule

// File: rtl/regfile_scoreboard.sv
// Purpose: 2-read/1-write register file with write-through bypass, optional hard-wired
//          zero register and a busy scoreboard for RAW hazard detection at decode.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   wr_en, wr_addr, wr_data        writeback port
//   rd_addr_a/b -> rd_data_a/b     combinational read ports (bypassed when enabled)
//   busy_a/b                       pending-write flag of the addressed register
//   issue_en, issue_addr           decode marks a destination as pending
//   flush                          synchronous clear of all pending flags
//   pending_cnt, sb_full           number of pending registers, all-pending flag
`timescale 1ns/1ps
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W   = cpu_pkg::ADDR_W,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              busy_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              busy_b,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              flush,
  output logic [ADDR_W:0]   pending_cnt,
  output logic              sb_full
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  w_busy;
  logic              w_wr_ok;
  logic              w_clr_ok;

  // Writes to the zero register are dropped so it never holds data.
  assign w_wr_ok  = wr_en && !(ZERO_REG && (wr_addr == '0));
  // A same-cycle issue to the written register keeps it busy.
  assign w_clr_ok = w_wr_ok && !(issue_en && (issue_addr == wr_addr));

  // Storage array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regs <= '{default: '0};
    end else if (w_wr_ok) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  regfile_sb_bits #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb_bits (
    .clk           (clk),
    .rst           (rst),
    .i_wr_en       (w_wr_ok),
    .i_wr_addr     (wr_addr),
    .i_issue_en    (issue_en),
    .i_issue_addr  (issue_addr),
    .i_flush       (flush),
    .o_busy        (w_busy),
    .o_pending_cnt (pending_cnt),
    .o_sb_full_c   (sb_full)
  );

  // Read port A with write-through bypass.
  always_comb begin
    rd_data_a = r_regs[rd_addr_a];
    busy_a    = w_busy[rd_addr_a];
    if (BYPASS && w_wr_ok && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
      if (w_clr_ok) busy_a = 1'b0;
    end
    if (ZERO_REG && (rd_addr_a == '0)) begin
      rd_data_a = '0;
      busy_a    = 1'b0;
    end
  end

  // Read port B with write-through bypass.
  always_comb begin
    rd_data_b = r_regs[rd_addr_b];
    busy_b    = w_busy[rd_addr_b];
    if (BYPASS && w_wr_ok && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
      if (w_clr_ok) busy_b = 1'b0;
    end
    if (ZERO_REG && (rd_addr_b == '0)) begin
      rd_data_b = '0;
      busy_b    = 1'b0;
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Purpose: directed self-checking bench for regfile_scoreboard; one instance with
//          bypass, one without, sharing all inputs.
`timescale 1ns/1ps
module tb_regfile_scoreboard;
  import cpu_pkg::*;

  logic      clk, rst;
  logic      wr_en, issue_en, flush;
  reg_addr_t wr_addr, rd_addr_a, rd_addr_b, issue_addr;
  word_t     wr_data;

  word_t          b_rd_a, b_rd_b, n_rd_a, n_rd_b;
  logic           b_busy_a, b_busy_b, n_busy_a, n_busy_b;
  logic [ADDR_W:0] b_cnt, n_cnt;
  logic           b_full, n_full;

  regfile_scoreboard #(.BYPASS(1'b1)) u_byp (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(b_rd_a), .busy_a(b_busy_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(b_rd_b), .busy_b(b_busy_b),
    .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush),
    .pending_cnt(b_cnt), .sb_full(b_full)
  );

  regfile_scoreboard #(.BYPASS(1'b0)) u_nob (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(n_rd_a), .busy_a(n_busy_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(n_rd_b), .busy_b(n_busy_b),
    .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush),
    .pending_cnt(n_cnt), .sb_full(n_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
    end else begin
      e.tag = "queue_empty";
      e.val = 'x;
    end
    n_checks++;
    assert (obs === e.val) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
    end
  endtask

  // Advance one clock; strobes are single-cycle pulses.
  task automatic cycle();
    @(posedge clk);
    #1;
    wr_en    = 1'b0;
    issue_en = 1'b0;
    flush    = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0; issue_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rd_addr_a = 4'd5;
    #1;
    push("rst_cnt", 32'd0);    pop_check(32'(b_cnt));
    push("rst_full", 32'd0);   pop_check(32'(b_full));
    push("rst_rd_r5", 32'd0);  pop_check(32'(b_rd_a));

    // Reset discards both data and pending state.
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
    issue_en = 1'b1; issue_addr = 4'd8; rd_addr_b = 4'd8;
    push("pre_rst_rd_r5", 32'hBEEF);
    push("pre_rst_cnt", 32'd1);
    push("pre_rst_busy_r8", 32'd1);
    cycle();
    pop_check(32'(b_rd_a)); pop_check(32'(b_cnt)); pop_check(32'(b_busy_b));
    rst = 1'b1;
    push("rst_rd_r5_cleared", 32'd0);
    push("rst_cnt_cleared", 32'd0);
    push("rst_busy_r8_cleared", 32'd0);
    #1;
    pop_check(32'(b_rd_a)); pop_check(32'(b_cnt)); pop_check(32'(b_busy_b));
    #1 rst = 1'b0;

    // Write/read with and without bypass.
    rd_addr_a = 4'd3;
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234;
    push("byp_same_cycle", 32'h1234);
    push("nobyp_same_cycle", 32'h0000);
    #1;
    pop_check(32'(b_rd_a)); pop_check(32'(n_rd_a));
    push("nobyp_next_cycle", 32'h1234);
    push("byp_next_cycle", 32'h1234);
    cycle();
    pop_check(32'(n_rd_a)); pop_check(32'(b_rd_a));

    // Zero register ignores writes and issues.
    rd_addr_a = 4'd0;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
    issue_en = 1'b1; issue_addr = 4'd0;
    push("r0_rd_same", 32'd0);
    push("r0_busy_same", 32'd0);
    #1;
    pop_check(32'(b_rd_a)); pop_check(32'(b_busy_a));
    push("r0_rd_next", 32'd0);
    push("r0_cnt", 32'd0);
    cycle();
    pop_check(32'(b_rd_a)); pop_check(32'(b_cnt));

    // Issue then writeback of r7.
    rd_addr_a = 4'd7;
    issue_en = 1'b1; issue_addr = 4'd7;
    push("r7_busy_issue_cycle", 32'd0);
    #1;
    pop_check(32'(b_busy_a));
    push("r7_busy_after_issue", 32'd1);
    push("r7_cnt_after_issue", 32'd1);
    cycle();
    pop_check(32'(b_busy_a)); pop_check(32'(b_cnt));
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h00AA;
    push("r7_busy_wb_byp", 32'd0);
    push("r7_rd_wb_byp", 32'h00AA);
    push("r7_busy_wb_nobyp", 32'd1);
    push("r7_rd_wb_nobyp", 32'h0000);
    #1;
    pop_check(32'(b_busy_a)); pop_check(32'(b_rd_a));
    pop_check(32'(n_busy_a)); pop_check(32'(n_rd_a));
    push("r7_cnt_after_wb", 32'd0);
    push("r7_busy_after_wb", 32'd0);
    cycle();
    pop_check(32'(b_cnt)); pop_check(32'(n_busy_a));

    // Simultaneous issue and writeback.
    issue_en = 1'b1; issue_addr = 4'd9;
    push("r9_cnt", 32'd1);
    cycle();
    pop_check(32'(b_cnt));
    rd_addr_a = 4'd2;
    issue_en = 1'b1; issue_addr = 4'd2;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h0005;
    push("r2_same_busy", 32'd1);
    push("r2_same_cnt", 32'd2);
    push("r2_same_rd", 32'h0005);
    cycle();
    pop_check(32'(b_busy_a)); pop_check(32'(b_cnt)); pop_check(32'(b_rd_a));
    issue_en = 1'b1; issue_addr = 4'd4;
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h0009;
    rd_addr_b = 4'd9;
    push("set_r4_clr_r9_cnt", 32'd2);
    push("r9_busy_cleared", 32'd0);
    push("r4_busy_set", 32'd1);
    cycle();
    pop_check(32'(b_cnt)); pop_check(32'(b_busy_b));
    rd_addr_a = 4'd4;
    #1;
    pop_check(32'(b_busy_a));
    issue_en = 1'b1; issue_addr = 4'd2;
    push("reissue_r2_cnt", 32'd2);
    cycle();
    pop_check(32'(b_cnt));
    wr_en = 1'b1; wr_addr = 4'd11; wr_data = 16'h0B0B;
    push("wr_nonbusy_cnt", 32'd2);
    cycle();
    pop_check(32'(b_cnt));

    // Fill the scoreboard, issue while full, then flush over an issue.
    for (int i = 1; i < 16; i++) begin
      issue_en = 1'b1; issue_addr = 4'(i);
      if (i == 14) begin
        push("cnt_at_14", 32'd14);
        push("full_at_14", 32'd0);
      end
      cycle();
      if (i == 14) begin
        pop_check(32'(b_cnt)); pop_check(32'(b_full));
      end
    end
    push("cnt_full", 32'd15);
    push("sb_full", 32'd1);
    #1;
    pop_check(32'(b_cnt)); pop_check(32'(b_full));
    issue_en = 1'b1; issue_addr = 4'd5;
    push("issue_while_full_cnt", 32'd15);
    cycle();
    pop_check(32'(b_cnt));
    rd_addr_a = 4'd6;
    flush = 1'b1; issue_en = 1'b1; issue_addr = 4'd6;
    push("flush_cnt", 32'd0);
    push("flush_full", 32'd0);
    push("flush_busy_r6", 32'd0);
    push("flush_nobyp_cnt", 32'd0);
    cycle();
    pop_check(32'(b_cnt)); pop_check(32'(b_full));
    pop_check(32'(b_busy_a)); pop_check(32'(n_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
